// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return (digit > 0) ? width / digit : 1;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder, chained DIGIT times per processing cycle.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor with valid/ready handshakes on both sides.
// Operands are consumed DIGIT bits per cycle, LSB first, through a full-adder ripple chain.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_w(NDIG);

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
      $error("serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] chain_s;
  logic             last_digit;

  assign chain_c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (chain_c[i]),
      .s  (chain_s[i]),
      .co (chain_c[i+1])
    );
  end

  assign last_digit = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction runs as a + ~b + ~cin, so the carry out doubles as "no borrow".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          sum_q   <= (sum_q >> DIGIT) | (WIDTH'(chain_s) << (WIDTH - DIGIT));
          carry_q <= chain_c[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (last_digit) ovf_q <= chain_c[DIGIT-1] ^ chain_c[DIGIT];
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock through a chain of DIGIT one-bit full-adder cells, with a registered carry between digits. A valid/ready handshake sits on input and output, so it drops into datapaths where area matters more than latency. It extends the team's single-bit full adder with width, digit-serial operation, subtract mode, signed-overflow detection and flow control.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DIGIT, 1, bits processed per cycle; must divide WIDTH; DIGIT=WIDTH gives a one-cycle RUN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
sub  in  1  0: a+b+cin; 1: a-b-cin
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry-out (sub: 1 = no borrow)
ovf  out  1  two's-complement overflow

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, asserted at any time including mid-RUN: state IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; all internal shift registers, carry register and digit counter cleared.
- NDIG = WIDTH/DIGIT. Counter width is clog2(NDIG), minimum 1 bit.
- Elaboration error if DIGIT<1, DIGIT>WIDTH, or WIDTH%DIGIT!=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge k:
    - Capture a into the A shift register.
    - Capture b into the B shift register, bitwise inverted when sub=1.
    - Carry register loads cin when sub=0, ~cin when sub=1.
    - Counter loads 0; go to RUN.
  - in_valid low: stay in IDLE; a, b, cin and sub are ignored.
- RUN (in_ready=0):
  - Each cycle, the DIGIT LSBs of A and B plus the carry register feed the fa_cell chain.
  - The DIGIT result bits shift into the MSB end of the sum register; A and B shift right by DIGIT.
  - The carry register takes the chain carry-out.
  - On the last digit (counter==NDIG-1), also register ovf = (carry into chain bit DIGIT-1) XOR (chain carry-out), then go to DONE.
  - Digits are processed at edges k+1..k+NDIG; out_valid goes high after edge k+NDIG.
- DONE:
  - out_valid=1; in_ready=0.
  - sum, cout (final carry register) and ovf are held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. sum/cout/ovf keep their last values.
  - in_valid is ignored in RUN and DONE; there is no input buffering.
- out_ready when out_valid=0 has no effect.
- Arithmetic is modulo 2^WIDTH; cout carries the (WIDTH+1)th bit; no saturation.
- Throughput: one operation per NDIG+2 cycles minimum (accept, NDIG RUN cycles, DONE handshake).

Decomposition:
- Package serial_adder_pkg: state enum (IDLE, RUN, DONE) and a localparam helper for NDIG and counter width.
- Sub-module fa_cell: one-bit combinational full adder (a, b, ci -> s, co), instantiated DIGIT times in a ripple chain.
- FSM, shift registers and counter live in serial_adder.

Test Plan:
- WIDTH=8, DIGIT=1; a=8'h5A, b=8'h3C, cin=0, sub=0 -> sum=8'h96, cout=0, ovf=1; out_valid rises exactly 8 edges after the accept edge.
- a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h80, b=8'h01, sub=1, cin=0 -> sum=8'h7F, cout=1, ovf=1.
- a=8'h10, b=8'h20, sub=1, cin=1 -> sum=8'hEF, cout=0 (borrow), ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> sum/cout/ovf unchanged, in_ready=0, no new capture. Releasing out_ready returns to IDLE in 1 cycle.
- Assert rst_n low after 3 RUN digits -> all outputs 0 and in_ready=1 immediately (asynchronous). The next operation 8'h01+8'h01 gives sum=8'h02.
- WIDTH=16, DIGIT=4; a=16'hFFFF, b=16'h0001, cin=1, sub=0 -> sum=16'h0001, cout=1, ovf=0; out_valid 4 edges after accept.
